pulp_icache_fetch_adapter: RTL

PULP_ICACHE_FETCH_ADAPTER -- requirements
Module: pulp_icache_fetch_adapter

---
 rtl/pulp_icache_adapter_pkg.sv | 22 ++
 rtl/pulp_icache_fetch_port.sv | 148 ++++++++++++++
 rtl/pulp_icache_fetch_adapter.sv | 64 ++++++
 3 files changed

// File: rtl/pulp_icache_adapter_pkg.sv
// Shared types for the instruction-cache fetch adapter: cut selection and
// per-port flush state.
package pulp_icache_adapter_pkg;

  typedef enum logic [1:0] {
    CUT_NONE = 2'd0,
    CUT_REQ  = 2'd1,
    CUT_RSP  = 2'd2
  } cut_mode_e;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_DRAIN = 2'd1,
    FS_FLUSH = 2'd2
  } flush_state_e;

  // Pointer width for a FIFO of the given depth; at least one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pulp_icache_fetch_port.sv
// One fetch port: selectable request/response cut, flush FSM and
// saturating stall counter.
module pulp_icache_fetch_port
  import pulp_icache_adapter_pkg::*;
#(
  parameter cut_mode_e   CutMode       = CUT_REQ,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned ReqDepth      = 2,
  parameter int unsigned StallCntWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_req_i,
  input  logic [AddrWidth-1:0]     fetch_addr_i,
  output logic                     fetch_gnt_o,
  output logic                     fetch_rvalid_o,
  output logic [DataWidth-1:0]     fetch_rdata_o,
  output logic                     fetch_rerror_o,
  input  logic                     flush_valid_i,
  output logic                     flush_ready_o,
  input  logic                     stall_clr_i,
  output logic [StallCntWidth-1:0] stall_cnt_o,
  output logic                     cache_valid_o,
  output logic [AddrWidth-1:0]     cache_addr_o,
  input  logic                     cache_ready_i,
  input  logic [DataWidth-1:0]     cache_rdata_i,
  input  logic                     cache_rerror_i,
  output logic                     cache_flush_valid_o,
  input  logic                     cache_flush_ready_i
);

  flush_state_e r_state, w_state_nxt;
  logic w_run, w_empty, w_xfer;
  logic [StallCntWidth-1:0] r_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= FS_RUN;
    else       r_state <= w_state_nxt;
  end

  // The cycle that first sees flush_valid_i already blocks new grants, so an
  // empty port reaches FLUSH after exactly one non-granting cycle.
  always_comb begin
    w_state_nxt         = r_state;
    w_run               = 1'b0;
    cache_flush_valid_o = 1'b0;
    flush_ready_o       = 1'b0;
    case (r_state)
      FS_RUN: begin
        if (flush_valid_i) w_state_nxt = w_empty ? FS_FLUSH : FS_DRAIN;
        else               w_run       = ~rst_i;
      end
      FS_DRAIN: begin
        if (!flush_valid_i) w_state_nxt = FS_RUN;
        else if (w_empty)   w_state_nxt = FS_FLUSH;
      end
      FS_FLUSH: begin
        cache_flush_valid_o = ~rst_i;
        if (cache_flush_ready_i && !rst_i) begin
          flush_ready_o = 1'b1;
          w_state_nxt   = FS_RUN;
        end
      end
      default: w_state_nxt = FS_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || stall_clr_i)
      r_stall <= '0;
    else if (fetch_req_i && !fetch_gnt_o && !(&r_stall))
      r_stall <= r_stall + 1'b1;
  end
  assign stall_cnt_o = r_stall;

  if (CutMode == CUT_REQ) begin : g_req
    localparam int unsigned PW = ptr_w(ReqDepth);
    localparam int unsigned CW = $clog2(ReqDepth + 1);
    logic [AddrWidth-1:0] r_mem [ReqDepth];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic w_full;

    assign w_full         = (r_cnt == CW'(ReqDepth));
    assign fetch_gnt_o    = fetch_req_i & ~w_full & w_run;
    assign cache_valid_o  = (r_cnt != '0) & ~rst_i;
    assign cache_addr_o   = r_mem[r_rptr];
    assign w_xfer         = cache_valid_o & cache_ready_i;
    assign fetch_rvalid_o = w_xfer;
    assign fetch_rdata_o  = cache_rdata_i;
    assign fetch_rerror_o = cache_rerror_i;
    assign w_empty        = (r_cnt == '0);

    // Explicit wrap keeps non-power-of-two depths correct.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (fetch_gnt_o) r_wptr <= (r_wptr == PW'(ReqDepth - 1)) ? '0 : r_wptr + 1'b1;
        if (w_xfer)      r_rptr <= (r_rptr == PW'(ReqDepth - 1)) ? '0 : r_rptr + 1'b1;
        r_cnt <= r_cnt + CW'(fetch_gnt_o) - CW'(w_xfer);
      end
    end

    always_ff @(posedge clk_i) begin
      if (fetch_gnt_o) r_mem[r_wptr] <= fetch_addr_i;
    end
  end else if (CutMode == CUT_RSP) begin : g_rsp
    logic                 r_rvalid, r_rerror;
    logic [DataWidth-1:0] r_rdata;

    assign cache_valid_o  = fetch_req_i & w_run;
    assign cache_addr_o   = fetch_addr_i;
    assign w_xfer         = cache_valid_o & cache_ready_i;
    assign fetch_gnt_o    = w_xfer;
    assign fetch_rvalid_o = r_rvalid;
    assign fetch_rdata_o  = r_rdata;
    assign fetch_rerror_o = r_rerror;
    assign w_empty        = ~r_rvalid;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
        r_rerror <= 1'b0;
      end else begin
        r_rvalid <= w_xfer;
        if (w_xfer) begin
          r_rdata  <= cache_rdata_i;
          r_rerror <= cache_rerror_i;
        end
      end
    end
  end else begin : g_none
    assign cache_valid_o  = fetch_req_i & w_run;
    assign cache_addr_o   = fetch_addr_i;
    assign w_xfer         = cache_valid_o & cache_ready_i;
    assign fetch_gnt_o    = w_xfer;
    assign fetch_rvalid_o = w_xfer;
    assign fetch_rdata_o  = cache_rdata_i;
    assign fetch_rerror_o = cache_rerror_i;
    assign w_empty        = 1'b1;
  end

endmodule

// File: rtl/pulp_icache_fetch_adapter.sv
// Multi-port adapter between core fetch ports and the instruction cache;
// each port is an independent pulp_icache_fetch_port.
module pulp_icache_fetch_adapter
  import pulp_icache_adapter_pkg::*;
#(
  parameter int unsigned NumFetchPorts  = 1,
  parameter int unsigned FetchAddrWidth = 32,
  parameter int unsigned FetchDataWidth = 32,
  parameter cut_mode_e   CutMode        = CUT_REQ,
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned StallCntWidth  = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NumFetchPorts-1:0]                      fetch_req_i,
  input  logic [NumFetchPorts-1:0][FetchAddrWidth-1:0]  fetch_addr_i,
  output logic [NumFetchPorts-1:0]                      fetch_gnt_o,
  output logic [NumFetchPorts-1:0]                      fetch_rvalid_o,
  output logic [NumFetchPorts-1:0][FetchDataWidth-1:0]  fetch_rdata_o,
  output logic [NumFetchPorts-1:0]                      fetch_rerror_o,
  input  logic [NumFetchPorts-1:0]                      flush_valid_i,
  output logic [NumFetchPorts-1:0]                      flush_ready_o,
  input  logic [NumFetchPorts-1:0]                      stall_clr_i,
  output logic [NumFetchPorts-1:0][StallCntWidth-1:0]   stall_cnt_o,
  output logic [NumFetchPorts-1:0]                      cache_valid_o,
  output logic [NumFetchPorts-1:0][FetchAddrWidth-1:0]  cache_addr_o,
  input  logic [NumFetchPorts-1:0]                      cache_ready_i,
  input  logic [NumFetchPorts-1:0][FetchDataWidth-1:0]  cache_rdata_i,
  input  logic [NumFetchPorts-1:0]                      cache_rerror_i,
  output logic [NumFetchPorts-1:0]                      cache_flush_valid_o,
  input  logic [NumFetchPorts-1:0]                      cache_flush_ready_i
);

  for (genvar g = 0; g < NumFetchPorts; g++) begin : g_port
    pulp_icache_fetch_port #(
      .CutMode       (CutMode),
      .AddrWidth     (FetchAddrWidth),
      .DataWidth     (FetchDataWidth),
      .ReqDepth      (ReqDepth),
      .StallCntWidth (StallCntWidth)
    ) u_port (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .fetch_req_i         (fetch_req_i[g]),
      .fetch_addr_i        (fetch_addr_i[g]),
      .fetch_gnt_o         (fetch_gnt_o[g]),
      .fetch_rvalid_o      (fetch_rvalid_o[g]),
      .fetch_rdata_o       (fetch_rdata_o[g]),
      .fetch_rerror_o      (fetch_rerror_o[g]),
      .flush_valid_i       (flush_valid_i[g]),
      .flush_ready_o       (flush_ready_o[g]),
      .stall_clr_i         (stall_clr_i[g]),
      .stall_cnt_o         (stall_cnt_o[g]),
      .cache_valid_o       (cache_valid_o[g]),
      .cache_addr_o        (cache_addr_o[g]),
      .cache_ready_i       (cache_ready_i[g]),
      .cache_rdata_i       (cache_rdata_i[g]),
      .cache_rerror_i      (cache_rerror_i[g]),
      .cache_flush_valid_o (cache_flush_valid_o[g]),
      .cache_flush_ready_i (cache_flush_ready_i[g])
    );
  end

endmodule
